// File: rtl/hbmc_pkg.sv
// Shared constants and helpers for the HyperBus memory controller data path.
package hbmc_pkg;

    // Memory-side data path is one DDR halfword wide
    localparam int HALFWORD_W      = 16;
    // Byte strobes covering one halfword
    localparam int HALFWORD_STRB_W = 2;

    // RWDS write-mask polarity: a 1 on RWDS masks (does not write) the byte
    localparam logic       MASK_ACTIVE = 1'b1;
    // Mask value while no halfword is presented
    localparam logic [1:0] MASK_RESET  = 2'b11;

    // Legal bus-side word widths
    localparam int LEGAL_DW_0 = 16;
    localparam int LEGAL_DW_1 = 32;
    localparam int LEGAL_DW_2 = 64;

    function automatic bit is_legal_data_width(input int dw);
        return (dw == LEGAL_DW_0) || (dw == LEGAL_DW_1) || (dw == LEGAL_DW_2);
    endfunction

    function automatic int halfwords_per_word(input int dw);
        return dw / HALFWORD_W;
    endfunction

    // Byte strobes (1 = written) to RWDS mask bits of the configured polarity
    function automatic logic [1:0] strb_to_mask(input logic [1:0] strb);
        return strb ^ {2{MASK_ACTIVE}};
    endfunction

endpackage

// File: rtl/hbmc_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and registered not-full flag.
// Storage is not reset; clearing the pointers discards any buffered data.
module hbmc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full,
    output logic                     empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    ZERO_C  = {(AW+1){1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             not_full_r;
    logic             push_s;
    logic             pop_s;

    assign push_s   = wr_en && not_full_r;
    assign pop_s    = rd_en && (count_r != ZERO_C);
    assign rd_data  = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign not_full = not_full_r;
    assign empty    = (count_r == ZERO_C);

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and the registered not-full flag
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= ZERO_C;
            not_full_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            not_full_r <= (count_nxt_s < DEPTH_C);
        end
    end

    // Entry storage written on accepted pushes
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/hbmc_wdata_serializer.sv
// HyperBus write-data buffer: FIFO of bus words plus a serializer that emits
// each word as 16-bit halfwords (low halfword first) with an RWDS write mask.
// Optional feature macro: HBMC_WDATA_MASK_EN keeps byte strobes per entry and
// drives m_mask from them; without it m_mask is 2'b00 while m_valid is high.
module hbmc_wdata_serializer
    import hbmc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [DATA_WIDTH-1:0]         s_din,
    input  logic [DATA_WIDTH/8-1:0]       s_strb,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   s_free,
    output logic [15:0]                   m_dout,
    output logic [1:0]                    m_mask,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int                 N        = halfwords_per_word(DATA_WIDTH);
    localparam int                 STRB_W   = DATA_WIDTH / 8;
    localparam int                 CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int                 IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);
    localparam logic [CW-1:0]      DEPTH_C  = CW'(FIFO_DEPTH);
`ifdef HBMC_WDATA_MASK_EN
    localparam int                 ENTRY_W  = DATA_WIDTH + STRB_W + 1;
`else
    localparam int                 ENTRY_W  = DATA_WIDTH + 1;
`endif

    if (!is_legal_data_width(DATA_WIDTH)) begin : g_bad_data_width
        $error("hbmc_wdata_serializer: DATA_WIDTH must be 16, 32 or 64");
    end
    if ((FIFO_DEPTH < 4) || (FIFO_DEPTH > 512) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hbmc_wdata_serializer: FIFO_DEPTH must be a power of two in 4..512");
    end

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } ser_state_e;

    logic [ENTRY_W-1:0]     wr_entry_s;
    logic [ENTRY_W-1:0]     rd_entry_s;
    logic [DATA_WIDTH-1:0]  e_data_s;
    logic [STRB_W-1:0]      e_strb_s;
    logic                   e_last_s;
    logic [CW-1:0]          fifo_count_s;
    logic                   fifo_not_full_s;
    logic                   fifo_empty_s;

    logic                   pop_s;
    logic                   advance_s;
    logic                   retire_s;
    logic [IDX_W-1:0]       idx_nxt_s;

    ser_state_e             state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DATA_WIDTH-1:0]  rest_data_r;
    logic [STRB_W-1:0]      rest_strb_r;
    logic                   burst_last_r;
    logic [15:0]            m_dout_r;
    logic [1:0]             m_mask_r;
    logic                   m_last_r;
    logic                   m_valid_r;

`ifdef HBMC_WDATA_MASK_EN
    assign wr_entry_s = {s_last, s_strb, s_din};
    assign e_strb_s   = rd_entry_s[DATA_WIDTH +: STRB_W];
`else
    // Strobes are not stored; every byte is treated as written
    logic unused_strb_s;
    assign unused_strb_s = ^s_strb;
    assign wr_entry_s    = {s_last, s_din};
    assign e_strb_s      = {STRB_W{1'b1}};
`endif
    assign e_data_s = rd_entry_s[DATA_WIDTH-1:0];
    assign e_last_s = rd_entry_s[ENTRY_W-1];

    hbmc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arstn    (arstn),
        .wr_en    (s_valid),
        .wr_data  (wr_entry_s),
        .rd_en    (pop_s),
        .rd_data  (rd_entry_s),
        .count    (fifo_count_s),
        .not_full (fifo_not_full_s),
        .empty    (fifo_empty_s)
    );

    assign s_ready   = fifo_not_full_s;
    assign s_free    = DEPTH_C - fifo_count_s;
    assign idx_nxt_s = idx_r + IDX_W'(1);

    // Serializer control: reload from the FIFO when idle or finishing a word
    always_comb begin
        pop_s     = 1'b0;
        advance_s = 1'b0;
        retire_s  = 1'b0;
        if (state_r == ST_EMPTY) begin
            pop_s = !fifo_empty_s;
        end else if (m_ready && (idx_r == IDX_LAST)) begin
            pop_s    = !fifo_empty_s;
            retire_s = fifo_empty_s;
        end else if (m_ready) begin
            advance_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Serializer FSM with registered halfword outputs
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r      <= ST_EMPTY;
            idx_r        <= {IDX_W{1'b0}};
            rest_data_r  <= {DATA_WIDTH{1'b0}};
            rest_strb_r  <= {STRB_W{1'b0}};
            burst_last_r <= 1'b0;
            m_dout_r     <= 16'h0000;
            m_mask_r     <= MASK_RESET;
            m_last_r     <= 1'b0;
            m_valid_r    <= 1'b0;
        end else if (pop_s) begin
            state_r      <= ST_HOLD;
            idx_r        <= {IDX_W{1'b0}};
            rest_data_r  <= e_data_s >> HALFWORD_W;
            rest_strb_r  <= e_strb_s >> HALFWORD_STRB_W;
            burst_last_r <= e_last_s;
            m_dout_r     <= e_data_s[HALFWORD_W-1:0];
            m_mask_r     <= strb_to_mask(e_strb_s[HALFWORD_STRB_W-1:0]);
            m_last_r     <= e_last_s && (IDX_LAST == {IDX_W{1'b0}});
            m_valid_r    <= 1'b1;
        end else if (advance_s) begin
            idx_r        <= idx_nxt_s;
            rest_data_r  <= rest_data_r >> HALFWORD_W;
            rest_strb_r  <= rest_strb_r >> HALFWORD_STRB_W;
            m_dout_r     <= rest_data_r[HALFWORD_W-1:0];
            m_mask_r     <= strb_to_mask(rest_strb_r[HALFWORD_STRB_W-1:0]);
            m_last_r     <= burst_last_r && (idx_nxt_s == IDX_LAST);
        end else if (retire_s) begin
            state_r      <= ST_EMPTY;
            idx_r        <= {IDX_W{1'b0}};
            m_dout_r     <= 16'h0000;
            m_mask_r     <= MASK_RESET;
            m_last_r     <= 1'b0;
            m_valid_r    <= 1'b0;
        end else begin
            state_r      <= state_r;
        end
    end

    assign m_dout  = m_dout_r;
    assign m_mask  = m_mask_r;
    assign m_last  = m_last_r;
    assign m_valid = m_valid_r;

endmodule

// File: tb/tb_hbmc_wdata_serializer.sv
// Self-checking bench for hbmc_wdata_serializer (DATA_WIDTH 32, FIFO_DEPTH 16).
// Expected halfwords are queued when a word is accepted and compared on each
// m_valid && m_ready handshake.
module tb_hbmc_wdata_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int N     = DW / 16;
    localparam int SW    = DW / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          arstn;
    logic [DW-1:0] s_din;
    logic [SW-1:0] s_strb;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_free;
    logic [15:0]   m_dout;
    logic [1:0]    m_mask;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;

    hbmc_wdata_serializer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .s_din   (s_din),
        .s_strb  (s_strb),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_free  (s_free),
        .m_dout  (m_dout),
        .m_mask  (m_mask),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dout;
        logic [1:0]  mask;
        logic        last;
    } hw_t;

    hw_t exp_q[$];
    hw_t held;
    int  tests = 0;
    int  fails = 0;
    int  rdy_mode = 0;
    bit  mon_en = 1'b0;
    bit  hold_prev = 1'b0;
    int  cur_run = 0;
    int  max_run = 0;
    int  last_cnt = 0;

    function automatic logic [1:0] exp_mask(input logic [1:0] st);
`ifdef HBMC_WDATA_MASK_EN
        return ~st;
`else
        return 2'b00;
`endif
    endfunction

    task automatic push_exp(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last);
        hw_t e;
        for (int h = 0; h < N; h++) begin
            e.dout = data[16*h +: 16];
            e.mask = exp_mask(strb[2*h +: 2]);
            e.last = last && (h == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Advance to the next falling edge, drive m_ready and check the output side
    task automatic step();
        hw_t e;
        @(negedge clk);
        if (mon_en) begin
            if (hold_prev) begin
                tests++;
                if (!(m_valid === 1'b1 && m_dout === held.dout && m_mask === held.mask && m_last === held.last)) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b d=%h m=%b l=%b, required v=1 d=%h m=%b l=%b",
                             m_valid, m_dout, m_mask, m_last, held.dout, held.mask, held.last);
                end
            end
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 99) < 60);
            endcase
            if (m_valid === 1'b1) cur_run++;
            else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
            if (m_valid === 1'b1 && m_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_halfword: got d=%h m=%b l=%b, required none", m_dout, m_mask, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_dout !== e.dout || m_mask !== e.mask || m_last !== e.last) begin
                        fails++;
                        $display("FAIL halfword: got d=%h m=%b l=%b, required d=%h m=%b l=%b",
                                 m_dout, m_mask, m_last, e.dout, e.mask, e.last);
                    end
                end
                if (m_last === 1'b1) last_cnt++;
            end
            hold_prev = (m_valid === 1'b1) && !m_ready;
            held.dout = m_dout;
            held.mask = m_mask;
            held.last = m_last;
        end else begin
            m_ready   = 1'b0;
            hold_prev = 1'b0;
        end
    endtask

    // Offer one word for one cycle; acc reports whether it was taken
    task automatic send(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last, output bit acc);
        s_din   = data;
        s_strb  = strb;
        s_last  = last;
        s_valid = 1'b1;
        acc     = (s_ready === 1'b1);
        if (acc) push_exp(data, strb, last);
        step();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        rdy_mode = 1;
        guard    = 0;
        while ((exp_q.size() != 0 || m_valid !== 1'b0) && guard < 2000) begin
            step();
            guard++;
        end
        tests++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: got %0d pending v=%b, required 0 pending v=0", exp_q.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        mon_en  = 1'b0;
        arstn   = 1'b0;
        s_valid = 1'b0;
        s_din   = '0;
        s_strb  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        tests++; if (s_free !== CW'(DEPTH)) begin fails++; $display("FAIL reset_s_free: got %0d, required %0d", s_free, DEPTH); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last: got %b, required 0", m_last); end
        tests++; if (m_mask !== 2'b11) begin fails++; $display("FAIL reset_m_mask: got %b, required 11", m_mask); end
        tests++; if (m_dout !== 16'h0000) begin fails++; $display("FAIL reset_m_dout: got %h, required 0000", m_dout); end
        arstn = 1'b1;
        #1;
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b, required 0", s_ready); end
        @(negedge clk);
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL ready_after_release: got %b, required 1", s_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        bit acc;
        rdy_mode = 1;
        send(32'hBBBB_AAAA, 4'hF, 1'b1, acc);
        tests++; if (!acc) begin fails++; $display("FAIL basic_accept: got %b, required 1", acc); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL latency_early: got m_valid %b, required 0", m_valid); end
        step();
        tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL latency_e1: got m_valid %b, required 1", m_valid); end
        drain();
    endtask

    task automatic test_strobe();
        bit acc;
        rdy_mode = 1;
        send(32'h4433_2211, 4'b0110, 1'b1, acc);
        drain();
    endtask

    task automatic test_full();
        bit acc;
        rdy_mode = 0;
        send(32'h0F0F_F0F0, 4'hF, 1'b1, acc);
        step();
        step();
        for (int i = 1; i <= 17; i++) begin
            send(32'h1000_0000 + DW'(i), 4'hF, (i == 16), acc);
            if (i <= 16) begin
                tests++; if (!acc) begin fails++; $display("FAIL full_accept_%0d: got %b, required 1", i, acc); end
            end else begin
                tests++; if (acc) begin fails++; $display("FAIL full_reject: got %b, required 0", acc); end
            end
            if (i == 16) begin
                tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready: got %b, required 0", s_ready); end
                tests++; if (s_free !== CW'(0)) begin fails++; $display("FAIL full_s_free: got %0d, required 0", s_free); end
            end
        end
        rdy_mode = 1;
        step();
        step();
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL prepop_s_ready: got %b, required 0", s_ready); end
        rdy_mode = 0;
        step();
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL postpop_s_ready: got %b, required 1", s_ready); end
        tests++; if (s_free !== CW'(1)) begin fails++; $display("FAIL postpop_s_free: got %0d, required 1", s_free); end
        drain();
    endtask

    task automatic test_back_to_back();
        bit acc;
        rdy_mode = 1;
        cur_run  = 0;
        max_run  = 0;
        last_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send({16'hC000 + 16'(i), 16'hD000 + 16'(i)}, 4'hF, (i == 7), acc);
        end
        drain();
        tests++; if (max_run != 2 * 8) begin fails++; $display("FAIL b2b_run: got %0d, required %0d", max_run, 2 * 8); end
        tests++; if (last_cnt != 1) begin fails++; $display("FAIL b2b_last_count: got %0d, required 1", last_cnt); end
    endtask

    task automatic test_random();
        bit acc;
        int accepted;
        int guard;
        rdy_mode = 2;
        accepted = 0;
        guard    = 0;
        while (accepted < 1000 && guard < 20000) begin
            if ($urandom_range(0, 3) != 0) begin
                send(DW'($urandom), SW'($urandom), ($urandom_range(0, 3) == 0), acc);
                if (acc) accepted++;
            end else begin
                step();
            end
            guard++;
        end
        tests++; if (accepted != 1000) begin fails++; $display("FAIL random_accept: got %0d, required 1000", accepted); end
        drain();
    endtask

    task automatic test_reset_mid();
        bit acc;
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send({16'hE100 + 16'(i), 16'hE200 + 16'(i)}, 4'h5, (i == 3), acc);
        end
        mon_en  = 1'b0;
        arstn   = 1'b0;
        m_ready = 1'b0;
        #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midrst_m_valid: got %b, required 0", m_valid); end
        tests++; if (m_mask !== 2'b11) begin fails++; $display("FAIL midrst_m_mask: got %b, required 11", m_mask); end
        tests++; if (m_dout !== 16'h0000 || m_last !== 1'b0) begin fails++; $display("FAIL midrst_m_dout: got %h/%b, required 0000/0", m_dout, m_last); end
        tests++; if (s_free !== CW'(DEPTH)) begin fails++; $display("FAIL midrst_s_free: got %0d, required %0d", s_free, DEPTH); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL midrst_s_ready: got %b, required 0", s_ready); end
        exp_q.delete();
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        send(32'h7766_5544, 4'hF, 1'b0, acc);
        send(32'h3322_1100, 4'hC, 1'b1, acc);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
